// File: rtl/serial7_rx_pkg.sv
// Shared definitions for the serial7_rx receiver.
//   DATA_W     : width of a received word (7 bits).
//   rx_state_t : receiver state encoding. ST_PARITY exists only when
//                SERIAL7_RX_PARITY_EN is defined.
//   rx_cnt_w() : width of the per-bit cycle counter for a given
//                CLKS_PER_BIT.
package serial7_rx_pkg;

  localparam int DATA_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SERIAL7_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_t;

  function automatic int rx_cnt_w(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/serial7_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so that a reset does not look like a start edge
// on an idle-high line.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   d     : asynchronous input
//   q     : synchronized output
module rx_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial7_rx.sv
// UART-style receiver for 7-bit words (start, 7 data bits LSB first,
// optional even parity, stop). Each good word is presented on data_out
// with a one-cycle data_valid strobe, ready to be captured by a
// downstream enabled holding register.
// Optional feature: define SERIAL7_RX_PARITY_EN to add the even-parity
// bit (10-bit frames) and a live parity_err output. Without it frames
// are 9 bits and parity_err is tied low.
// Parameters:
//   CLKS_PER_BIT : clk cycles per serial bit (even, >= 4)
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   rxd        : serial line, asynchronous, idle high
//   data_out   : last good word received
//   data_valid : one-cycle pulse when data_out updates
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   parity_err : one-cycle pulse on parity mismatch
//   busy       : high whenever the receiver is not idle
module serial7_rx
  import serial7_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [6:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = rx_cnt_w(CLKS_PER_BIT);
  // START waits half a bit so that every later sample lands mid-bit.
  localparam logic [CW-1:0] LIM_START = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LIM_BIT   = CW'(CLKS_PER_BIT - 1);

  logic rx_s;   // synchronized line
  logic rx_d;   // one-cycle delayed copy for falling-edge detection

  rx_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rx_s)
  );

  rx_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
`ifdef SERIAL7_RX_PARITY_EN
  logic               par_q, par_d;     // latched parity mismatch
  logic               perr_q, perr_d;
`endif

  logic [CW-1:0] limit;
  logic          at_limit;

  always_comb begin
    limit    = (state_q == ST_START) ? LIM_START : LIM_BIT;
    at_limit = (cnt_q == limit);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef SERIAL7_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // A fresh 1->0 edge is required; a line still low after a
        // framing error does not restart reception.
        if (!rx_s && rx_d) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (at_limit) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            bit_d   = 3'd0;
`ifdef SERIAL7_RX_PARITY_EN
            par_d   = 1'b0;
`endif
          end else begin
            state_d = ST_IDLE;   // false start: glitch on the line
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (at_limit) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd6) begin
`ifdef SERIAL7_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef SERIAL7_RX_PARITY_EN
      ST_PARITY: begin
        if (at_limit) begin
          cnt_d   = '0;
          // Even parity: data bits plus parity bit must XOR to 0.
          par_d   = (^shift_q) ^ rx_s;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      ST_STOP: begin
        if (at_limit) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
`ifdef SERIAL7_RX_PARITY_EN
          if (rx_s && !par_q) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
          end
          perr_d = par_q;
`else
          if (rx_s) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
          end
`endif
          ferr_d = !rx_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_d    <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SERIAL7_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      rx_d    <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef SERIAL7_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef SERIAL7_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial7_rx.sv
// Bench for serial7_rx: table of frames plus hand-written sequences for
// the glitch and mid-frame reset cases. Expected output events (word,
// flags and arrival cycle) are queued when a frame is driven and popped
// when the receiver pulses an output.
module tb_serial7_rx;

  localparam int N = 16;
  localparam int H = N / 2;
`ifdef SERIAL7_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_CYC = (9 + PAR) * N;
  // Pin edge -> edge detect (2) -> START sample (H) -> STOP sample
  // ((8+PAR)*N) -> registered outputs (1).
  localparam int LAT = 2 + H + (8 + PAR) * N + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [6:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  serial7_rx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  // {cycle[31:0], data_out[6:0], valid, frame_err, parity_err}
  logic [41:0] exp_q[$];
  int valid_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (data_valid || frame_err || parity_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: dout=0x%0h v=%0b f=%0b p=%0b cycle %0d",
                 data_out, data_valid, frame_err, parity_err, cyc);
      end else begin
        logic [41:0] e;
        e = exp_q.pop_front();
        check("out_flags", {22'd0, data_out, data_valid, frame_err, parity_err}, {22'd0, e[9:0]});
        check("out_cycle", cyc, e[41:10]);
      end
      if (data_valid) valid_cyc.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  // All drives happen 1 time unit after a rising edge.
  task automatic idle_cycles(input int n);
    rxd = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (N) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_neg(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic stop, input logic flip,
                            input logic [9:0] exp_flags, input logic expect_out);
    int c0;
    c0 = cyc;
    if (expect_out) exp_q.push_back({32'(c0 + LAT), exp_flags});
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(d[i]);
    if (PAR == 1) drive_bit((^d) ^ flip);
    drive_bit(stop);
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [6:0] data;
    logic       stop;
    logic       flip;
    int         gap;
    logic [6:0] exp_dout;
    logic       exp_v;
    logic       exp_f;
    logic       exp_p;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [6:0] r;
    int c0;
    int t;

    // Stimulus table
    vecs.push_back('{7'h55, 1'b1, 1'b0, 2*N, 7'h55, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{7'h2A, 1'b0, 1'b0, 2*N, 7'h55, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{7'h41, 1'b1, 1'b0, 2*N, 7'h41, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{7'h7F, 1'b1, 1'b0, 0,   7'h7F, 1'b1, 1'b0, 1'b0});
`ifdef SERIAL7_RX_PARITY_EN
    vecs.push_back('{7'h03, 1'b1, 1'b1, 2*N, 7'h7F, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{7'h03, 1'b1, 1'b0, 2*N, 7'h03, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{7'h15, 1'b0, 1'b1, 2*N, 7'h03, 1'b0, 1'b1, 1'b1});
`endif
    for (int i = 0; i < 2; i++) begin
      r = 7'($urandom_range(0, 127));
      vecs.push_back('{r, 1'b1, 1'b0, $urandom_range(1, 3*N), r, 1'b1, 1'b0, 1'b0});
    end

    // Reset
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out",   {25'd0, data_out}, 32'd0);
    check("reset_data_valid", {31'd0, data_valid}, 32'd0);
    check("reset_frame_err",  {31'd0, frame_err}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    check("reset_busy",       {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven frames
    foreach (vecs[i]) begin
      idle_cycles(vecs[i].gap);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].flip,
                 {vecs[i].exp_dout, vecs[i].exp_v, vecs[i].exp_f, vecs[i].exp_p}, 1'b1);
      check("busy_after_frame", {31'd0, busy}, 32'd0);
    end

    // Back-to-back frames 0x41 then 0x7F: valid pulses one frame apart
    if (valid_cyc.size() >= 3) begin
      check("b2b_spacing", 32'(valid_cyc[2] - valid_cyc[1]), 32'(FRAME_CYC));
    end else begin
      check("b2b_valid_count", 32'(valid_cyc.size()), 32'd3);
    end

    // Glitch: 3-cycle low pulse, false start, no outputs
    idle_cycles(2*N);
    c0 = cyc;
    rxd = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    wait_neg(c0 + 2 + H);
    check("glitch_busy_at_sample", {31'd0, busy}, 32'd1);
    wait_neg(c0 + 2 + H + 1);
    check("glitch_busy_after", {31'd0, busy}, 32'd0);
    check("glitch_data_out", {25'd0, data_out}, {25'd0, vecs[vecs.size()-1].exp_dout});
    @(posedge clk);
    #1;

    // Reset during data bit 3 of 0x33
    idle_cycles(2*N);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rxd = 1'b0;
    repeat (H) begin
      @(posedge clk);
      #1;
    end
    check("midreset_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_data_out",   {25'd0, data_out}, 32'd0);
    check("midreset_data_valid", {31'd0, data_valid}, 32'd0);
    check("midreset_frame_err",  {31'd0, frame_err}, 32'd0);
    check("midreset_parity_err", {31'd0, parity_err}, 32'd0);
    check("midreset_busy",       {31'd0, busy}, 32'd0);
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle_cycles(2*N);
    send_frame(7'h12, 1'b1, 1'b0, {7'h12, 1'b1, 1'b0, 1'b0}, 1'b1);

    // Drain, bounded
    t = 0;
    while (exp_q.size() != 0 && t < 4*FRAME_CYC) begin
      @(posedge clk);
      t++;
    end
    idle_cycles(4);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
